alu_writeback: RTL
==================

# alu_writeback

Writeback/commit stage directly downstream of the ALU in the ez8 core. Each cycle it takes the ALU's result and write-enables, commits the result to the accumulator or to the register-file write port, and updates the Z/C status flags. It owns the skip-squash state, the interrupt-enable bit toggled by return-from-interrupt, and the read bypass that feeds the ALU `regvalue` operand.

## Interface
- `ADDR_WIDTH`, default 8: register-file address width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: pipeline hold; no state changes while high.
- `ex_valid` in 1: the ALU stage holds a real instruction this cycle.
- `ex_addr` in ADDR_WIDTH: destination register of the ALU-stage instruction.
- `alu_result` in 8: ALU result.
- `accum_write`, `reg_write`, `z_write`, `c_write` in 1 each: ALU write enables.
- `zout`, `cout` in 1 each: ALU flag values.
- `retint`, `skip` in 1 each: ALU return-from-interrupt and skip requests.
- `int_enter` in 1: the interrupt controller is vectoring this cycle.
- `rd_addr` in ADDR_WIDTH: register-file read address for the ALU operand.
- `rf_rdata` in 8: raw register-file read data.
- `regvalue` out 8: bypassed operand to the ALU.
- `accum` out 8: accumulator, to the ALU.
- `z_flag`, `c_flag` out 1 each: status flags; `c_flag` drives ALU `cin`.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out ADDR_WIDTH: register-file write address.
- `rf_wdata` out 8: register-file write data.
- `squash` out 1: the ALU-stage instruction is being skipped; upstream must not fetch side effects from it.
- `int_en` out 1: global interrupt enable.

## Operation
- Accept condition: `accept = ex_valid && !stall && !squash`.
- Kill condition: `kill = ex_valid && !stall && squash`. A killed instruction updates nothing except clearing `squash`.
- On accept:
  - If `accum_write`: `accum <= alu_result`.
  - If `z_write`: `z_flag <= zout`. If `c_write`: `c_flag <= cout`.
  - If `reg_write`: `rf_we <= 1`, `rf_waddr <= ex_addr`, `rf_wdata <= alu_result`.
  - If `skip`: `squash <= 1`.
  - If `retint`: `int_en <= 1`.
- `rf_we` is a one-cycle registered pulse. It is cleared on any edge where the current instruction is not an accepted `reg_write`, including stalled edges. It is never re-issued.
- Bypass (combinational): `regvalue = (rf_we && rd_addr == rf_waddr) ? rf_wdata : rf_rdata`.
- `int_enter` (not gated by stall): `int_en <= 0`.
- `int_enter` and an accepted `retint` on the same edge: `int_enter` wins, so `int_en = 0`.
- A killed instruction's `skip`, `retint`, and writes are ignored. `squash` never chains.
- `squash` and `int_enter` on the same edge: `squash` still clears only via the kill condition, so it persists across the vector.
- Reset values:
  - `accum`, `rf_wdata`, `rf_waddr`: 0.
  - `z_flag`, `c_flag`, `rf_we`, `squash`, `int_en`: 0.
  - Shadow registers: 0.
- Reset asserted mid-operation forces all state to these values immediately; any pending `rf_we` is dropped.

## Timing
- One-cycle commit latency: the ALU outputs in cycle N are visible on `accum`, the flags, and the `rf_*` outputs in cycle N+1.
- The register file writes at the end of cycle N+1.
- The bypass covers exactly the read in cycle N+1. A back-to-back dependent instruction therefore needs no stall.
- `squash` is high for the cycle(s) the next instruction is in the ALU stage. It holds through stalls and clears on the edge that kills that instruction.
- Stall freezes `accum`, the flags, `squash`, `int_en`, and the shadow registers.

## Configuration
- Macro `ALU_WB_SHADOW_EN`.
- Defined:
  - `int_enter` copies `accum`, `z_flag`, and `c_flag` into shadow registers on the same edge; this uses the pre-edge values and applies even during stall.
  - An accepted `retint` restores all three from the shadow registers.
  - The restore overrides that instruction's `accum_write`, `z_write`, and `c_write`. The `reg_write` path is unaffected.
- Undefined: no shadow registers; `retint` only sets `int_en`.

## Test plan
- Reset, then accepted `accum_write` with `alu_result=0x5A`, `z_write=1`, `zout=0` -> next cycle `accum=0x5A`, `z_flag=0`, `rf_we=0`.
- Accepted `reg_write` with `ex_addr=0x12`, `alu_result=0x33`, and `rd_addr=0x12`, `rf_rdata=0x00` in the following cycle -> `rf_we=1` for exactly one cycle, `rf_waddr=0x12`, `regvalue=0x33`.
- Accepted `skip=1`, then a following instruction with `accum_write=1`, `alu_result=0xFF` and `stall=1` for 2 cycles -> `squash` stays 1 during the stall, `accum` is unchanged, and `squash=0` after the kill edge.
- `retint` and `int_enter` asserted on the same accepted edge -> `int_en=0`. `retint` alone -> `int_en=1`.
- With `ALU_WB_SHADOW_EN`:
  - Start from `accum=0x21`, `c_flag=1`, then `int_enter`, then write `accum=0x00` with `c_flag=0`.
  - Then `retint` with `accum_write=1`, `alu_result=0x77`.
  - Required: `accum=0x21`, `c_flag=1`, `int_en=1`.
- Assert `reset` mid-cycle while `rf_we=1` and `squash=1` -> all outputs go to 0 asynchronously, and no write appears after release.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback/commit stage after the ez8 ALU: commits accumulator, flags and register-file writes,
// tracks skip-squash and interrupt enable. Optional macro ALU_WB_SHADOW_EN adds interrupt shadow registers.
module alu_writeback #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  ex_valid,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [7:0]            alu_result,
  input  logic                  accum_write,
  input  logic                  reg_write,
  input  logic                  z_write,
  input  logic                  c_write,
  input  logic                  zout,
  input  logic                  cout,
  input  logic                  retint,
  input  logic                  skip,
  input  logic                  int_enter,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rf_rdata,
  output logic [7:0]            regvalue,
  output logic [7:0]            accum,
  output logic                  z_flag,
  output logic                  c_flag,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [7:0]            rf_wdata,
  output logic                  squash,
  output logic                  int_en
);

  logic       accept;
  logic       kill;
  logic       restore;
  logic [7:0] shadow_accum;
  logic       shadow_z;
  logic       shadow_c;

  assign accept = ex_valid && !stall && !squash;
  assign kill   = ex_valid && !stall && squash;

  // The register file writes at the end of the cycle after commit, so this covers that one read.
  assign regvalue = (rf_we && rd_addr == rf_waddr) ? rf_wdata : rf_rdata;

`ifdef ALU_WB_SHADOW_EN
  assign restore = accept && retint;

  // Capture uses pre-edge values and ignores stall, matching the interrupt vector timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_accum <= 8'h00;
      shadow_z     <= 1'b0;
      shadow_c     <= 1'b0;
    end else if (int_enter) begin
      shadow_accum <= accum;
      shadow_z     <= z_flag;
      shadow_c     <= c_flag;
    end
  end
`else
  assign restore      = 1'b0;
  assign shadow_accum = 8'h00;
  assign shadow_z     = 1'b0;
  assign shadow_c     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accum    <= 8'h00;
      z_flag   <= 1'b0;
      c_flag   <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= 8'h00;
      squash   <= 1'b0;
      int_en   <= 1'b0;
    end else begin
      // Single-cycle pulse: dropped on every edge that is not an accepted register write.
      rf_we <= accept && reg_write;
      if (accept && reg_write) begin
        rf_waddr <= ex_addr;
        rf_wdata <= alu_result;
      end

      if (restore) begin
        accum  <= shadow_accum;
        z_flag <= shadow_z;
        c_flag <= shadow_c;
      end else if (accept) begin
        if (accum_write) accum  <= alu_result;
        if (z_write)     z_flag <= zout;
        if (c_write)     c_flag <= cout;
      end

      // A killed instruction cannot set squash again, so skips never chain.
      if (accept && skip)
        squash <= 1'b1;
      else if (kill)
        squash <= 1'b0;

      if (int_enter)
        int_en <= 1'b0;
      else if (accept && retint)
        int_en <= 1'b1;
    end
  end

endmodule
